// File: rtl/ps2_scancode.sv
// PS/2 keyboard receiver and set-2 scancode decoder.
// Synchronises and glitch-filters the raw PS/2 lines and assembles 11-bit frames.
// E0/F0 prefixes are stripped, E1 (Pause) sequences and controller replies are discarded.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_scancode #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       strobe,
    output logic       pressed,
    output logic       extended,
    output logic       error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, SKIP} state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic [9:0]    shreg;
    logic [10:0]   frame;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          parity_ok, frame_ok;
    logic          rx_valid, rx_err;
    logic [7:0]    rx_byte;

    state_t        state, state_next;
    logic          rel, rel_next, ext, ext_next;
    logic [2:0]    skip_cnt, skip_next;
    logic          strobe_next, pressed_next, extended_next;
    logic [7:0]    code_next;

    // The filtered clock is about to be accepted low: this is a sampling edge.
    assign fall  = filt_clk && !clk_s2 && (filt_cnt == FW'(FILTER_LEN - 1));
    // Frame as it will look once the current data bit is shifted in (bit 0 = start).
    assign frame = {dat_s2, shreg};

    // Two-stage synchronisers; lines idle high.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: a new clock level must persist FILTER_LEN cycles to be accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    // Frame validity: start low, stop high, and optionally odd parity.
    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        parity_ok = ^frame[9:1];
`else
        parity_ok = 1'b1;
`endif
        frame_ok = !frame[0] && frame[10] && parity_ok;
    end

    // Bit shifter, bit counter and inter-bit timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            to_cnt   <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_byte  <= '0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (fall) begin
                shreg  <= frame[10:1];
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt  <= '0;
                    rx_valid <= frame_ok;
                    rx_err   <= !frame_ok;
                    rx_byte  <= frame[8:1];
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt == 4'd0) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                to_cnt  <= '0;
                bit_cnt <= '0;
                rx_err  <= 1'b1;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

    // Decoder next-state and output logic.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_next    = state;
        rel_next      = rel;
        ext_next      = ext;
        skip_next     = skip_cnt;
        strobe_next   = 1'b0;
        code_next     = code;
        pressed_next  = pressed;
        extended_next = extended;
        if (rx_err) begin
            rel_next = 1'b0;
            ext_next = 1'b0;
        end else if (rx_valid) begin
            case (state)
                IDLE: begin
                    case (rx_byte)
                        8'hE0: ext_next = 1'b1;
                        8'hF0: rel_next = 1'b1;
                        8'hE1: begin
                            state_next = SKIP;
                            skip_next  = 3'd7;
                            rel_next   = 1'b0;
                            ext_next   = 1'b0;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ; // controller replies
                        default: begin
                            strobe_next   = 1'b1;
                            code_next     = rx_byte;
                            pressed_next  = !rel;
                            extended_next = ext;
                            rel_next      = 1'b0;
                            ext_next      = 1'b0;
                        end
                    endcase
                end
                SKIP: begin
                    if (skip_cnt == 3'd1) begin
                        state_next = IDLE;
                        skip_next  = 3'd0;
                    end else begin
                        skip_next = skip_cnt - 3'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Decoder state and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rel      <= 1'b0;
            ext      <= 1'b0;
            skip_cnt <= '0;
            strobe   <= 1'b0;
            code     <= '0;
            pressed  <= 1'b0;
            extended <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_next;
            rel      <= rel_next;
            ext      <= ext_next;
            skip_cnt <= skip_next;
            strobe   <= strobe_next;
            code     <= code_next;
            pressed  <= pressed_next;
            extended <= extended_next;
            error    <= rx_err;
        end
    end

endmodule

// File: tb/tb_ps2_scancode.sv
// Self-checking bench for ps2_scancode: directed PS/2 frames with a scoreboard of expected events.
module tb_ps2_scancode;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 2000;
    localparam int HALF       = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] code;
    logic       strobe, pressed, extended, error;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       pressed;
        logic       extended;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  compared   = 0;
    int  mismatched = 0;

    ps2_scancode #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock    (clock),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .code     (code),
        .strobe   (strobe),
        .pressed  (pressed),
        .extended (extended),
        .error    (error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic expect_key(input logic [7:0] c, input logic p, input logic x);
        exp_q.push_back('{err: 1'b0, code: c, pressed: p, extended: x});
    endtask

    task automatic expect_err();
        exp_q.push_back('{err: 1'b1, code: 8'h00, pressed: 1'b0, extended: 1'b0});
    endtask

    // Drive the first nbits of a frame, device-style: data changes while ps2_clk is high.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (HALF / 2) @(posedge clock);
            ps2_clk = 1'b0;
            repeat (HALF) @(posedge clock);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(posedge clock);
        end
        ps2_dat = 1'b1;
        repeat (HALF) @(posedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(b, 1'b0, 1'b0, 11);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clock);
        repeat (5) @(posedge clock);
        check(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every strobe or error pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (!reset && (strobe || error)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'b0, strobe, error}, 32'd0);
            end else begin
                ev = exp_q.pop_front();
                check("event_kind", {30'b0, strobe, error}, ev.err ? 32'd1 : 32'd2);
                if (!ev.err) begin
                    check("code", {24'b0, code}, {24'b0, ev.code});
                    check("pressed", {31'b0, pressed}, {31'b0, ev.pressed});
                    check("extended", {31'b0, extended}, {31'b0, ev.extended});
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clock);
        check("reset_code", {24'b0, code}, 32'h00);
        check("reset_strobe", {31'b0, strobe}, 32'd0);
        check("reset_pressed", {31'b0, pressed}, 32'd0);
        check("reset_extended", {31'b0, extended}, 32'd0);
        check("reset_error", {31'b0, error}, 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clock);

        // Plain make code.
        expect_key(8'h1C, 1'b1, 1'b0);
        send_frame(8'h1C);
        wait_drain("drain_make");

        // Break code.
        expect_key(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0);
        send_frame(8'h1C);
        wait_drain("drain_break");

        // Extended break.
        expect_key(8'h6B, 1'b0, 1'b1);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h6B);
        wait_drain("drain_ext_break");

        // Pause sequence swallowed, then a normal key.
        expect_key(8'h29, 1'b1, 1'b0);
        send_frame(8'hE1);
        send_frame(8'h14);
        send_frame(8'h77);
        send_frame(8'hE1);
        send_frame(8'hF0);
        send_frame(8'h14);
        send_frame(8'hF0);
        send_frame(8'h77);
        send_frame(8'h29);
        wait_drain("drain_pause");

        // Controller replies are dropped without disturbing a pending E0.
        expect_key(8'h75, 1'b1, 1'b1);
        send_frame(8'hFA);
        send_frame(8'hE0);
        send_frame(8'hAA);
        send_frame(8'h75);
        wait_drain("drain_replies");

        // Wrong parity.
`ifdef PS2_PARITY_CHECK_EN
        expect_err();
`else
        expect_key(8'h1C, 1'b1, 1'b0);
`endif
        send_bits(8'h1C, 1'b1, 1'b0, 11);
        wait_drain("drain_parity");

        // Bad stop bit: error, and the pending E0 is forgotten.
        expect_err();
        expect_key(8'h1C, 1'b1, 1'b0);
        send_frame(8'hE0);
        send_bits(8'h33, 1'b0, 1'b1, 11);
        send_frame(8'h1C);
        wait_drain("drain_framing");

        // Timeout after a partial frame, then normal reception resumes.
        expect_err();
        send_bits(8'h5A, 1'b0, 1'b0, 5);
        repeat (TIMEOUT - 100) @(posedge clock);
        check("no_early_timeout", exp_q.size(), 1);
        repeat (200) @(posedge clock);
        check("timeout_fired", exp_q.size(), 0);
        expect_key(8'h5A, 1'b1, 1'b0);
        send_frame(8'h5A);
        wait_drain("drain_timeout");

        // Short glitches on ps2_clk must not shift anything.
        for (int i = 0; i < 6; i++) begin
            ps2_clk = 1'b0;
            @(posedge clock);
            ps2_clk = 1'b1;
            repeat (12) @(posedge clock);
        end
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 3) @(posedge clock);
        ps2_clk = 1'b1;
        repeat (20) @(posedge clock);
        check("glitch_bit_cnt", {28'b0, dut.bit_cnt}, 32'd0);
        expect_key(8'h34, 1'b1, 1'b0);
        send_frame(8'h34);
        wait_drain("drain_glitch");

        // Reset in the middle of a frame.
        send_bits(8'h33, 1'b0, 1'b0, 4);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        expect_key(8'h16, 1'b1, 1'b0);
        send_frame(8'h16);
        wait_drain("drain_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
